inst_fetch_ctrl: RTL and testbench

- Sequences the registered-output instruction ROM for the single-cycle MIPS core.
- Owns the fetch PC and drives the ROM word address.
- Hides the ROM's one-cycle read latency from the consumer: delivers a word plus a valid flag, and supports stall (replay), redirect (branch/jump, zero bubble) and fault-halt on bad fetch addresses.
- Sits between the ROM and the decode/next-PC logic.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_addr_check.sv | 15 +
 rtl/inst_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;

    // Sequential successor; wraps modulo 2^32, the range check stops any wrap from issuing.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational fetch-address legality: word aligned and inside the ROM byte range.
module fetch_addr_check #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [31:0] addr_i,
    output logic        aligned_o,
    output logic        in_range_o,
    output logic        ok_o
);

    assign aligned_o  = (addr_i[1:0] == 2'b00);
    assign in_range_o = ((addr_i >> (ADDR_WIDTH + 2)) == 32'd0);
    assign ok_o       = aligned_o & in_range_o;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for a registered-output instruction ROM (one-cycle read latency).
// Optional perf counters are enabled by defining INST_FETCH_PERF_EN.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall_in,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic [31:0]  rom_addr,
    input  logic [31:0]  rom_data,
    output logic [31:0]  inst_out,
    output logic [31:0]  pc_out,
    output logic         inst_valid,
    output logic         fault,
    output logic [31:0]  fault_pc,
    output fetch_state_e state_dbg
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  stall_count,
    output logic [15:0]  redirect_count
`endif
);

    // Handshake: a word is accepted on a rising edge with inst_valid=1 and stall_in=0;
    // while stall_in=1 the same word/pc is replayed and presented again next cycle.

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic redir_aligned, redir_in_range, redir_ok;
    logic fetch_aligned, fetch_in_range, fetch_ok;
    logic unused_chk;

    fetch_addr_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_redir_chk (
        .addr_i     (redirect_pc),
        .aligned_o  (redir_aligned),
        .in_range_o (redir_in_range),
        .ok_o       (redir_ok)
    );

    fetch_addr_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_fetch_chk (
        .addr_i     (fetch_pc_q),
        .aligned_o  (fetch_aligned),
        .in_range_o (fetch_in_range),
        .ok_o       (fetch_ok)
    );

    assign unused_chk = ^{redir_aligned, redir_in_range, fetch_aligned, fetch_in_range};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        fault_pc_d = fault_pc_q;
        rom_addr   = resp_pc_q;

        if (redirect_valid) begin
            // Redirect wins over stall and is honoured in every state.
            if (redir_ok) begin
                rom_addr   = redirect_pc;
                resp_pc_d  = redirect_pc;
                fetch_pc_d = next_seq_pc(redirect_pc);
                state_d    = RUN;
            end else begin
                state_d    = FAULT;
                fault_pc_d = redirect_pc;
                if (state_q == FAULT) begin
                    rom_addr = fault_pc_q & ~32'd3;
                end
            end
        end else begin
            case (state_q)
                BOOT: begin
                    rom_addr   = fetch_pc_q;
                    resp_pc_d  = fetch_pc_q;
                    fetch_pc_d = next_seq_pc(fetch_pc_q);
                    state_d    = RUN;
                end
                RUN: begin
                    if (stall_in) begin
                        rom_addr = resp_pc_q;
                    end else if (fetch_ok) begin
                        rom_addr   = fetch_pc_q;
                        resp_pc_d  = fetch_pc_q;
                        fetch_pc_d = next_seq_pc(fetch_pc_q);
                    end else begin
                        rom_addr   = fetch_pc_q;
                        state_d    = FAULT;
                        fault_pc_d = fetch_pc_q;
                    end
                end
                FAULT: begin
                    rom_addr = fault_pc_q & ~32'd3;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end

        if (reset) begin
            rom_addr = RESET_PC;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            fault_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign inst_valid = (state_q == RUN);
    assign fault      = (state_q == FAULT);
    assign fault_pc   = fault_pc_q;
    assign pc_out     = resp_pc_q;
    assign inst_out   = inst_valid ? rom_data : MIPS_NOP;
    assign state_dbg  = state_q;

`ifdef INST_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic [15:0] redir_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            redir_cnt_q <= 16'd0;
        end else begin
            if (inst_valid && !stall_in && fetch_cnt_q != '1) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (inst_valid && stall_in && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_valid && redir_ok && redir_cnt_q != '1) begin
                redir_cnt_q <= redir_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_count    = fetch_cnt_q;
    assign stall_count    = stall_cnt_q;
    assign redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a registered-output ROM model (ADDR_WIDTH=8).
// Counter checks are compiled in when INST_FETCH_PERF_EN is defined.
module tb_inst_fetch_ctrl;
    import fetch_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         stall_in;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [31:0]  rom_addr;
    logic [31:0]  rom_data;
    logic [31:0]  inst_out;
    logic [31:0]  pc_out;
    logic         inst_valid;
    logic         fault;
    logic [31:0]  fault_pc;
    fetch_state_e state_dbg;
`ifdef INST_FETCH_PERF_EN
    logic [31:0]  fetch_count;
    logic [31:0]  stall_count;
    logic [15:0]  redirect_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    inst_fetch_ctrl #(.ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .inst_valid     (inst_valid),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .state_dbg      (state_dbg)
`ifdef INST_FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count),
        .redirect_count (redirect_count)
`endif
    );

    // Clock / reset block
    always #5 clock = ~clock;

    // Registered-output ROM: data for an address appears one cycle later
    always @(posedge clock) rom_data <= mem[rom_addr[9:2]];

    // Driver tasks
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rv, input logic [31:0] rp);
        reset          = rst;
        stall_in       = stl;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, "_pc"}, pc_out, pc);
        check({tag, "_inst"}, inst_out, inst);
    endtask

    task automatic expect_idle(input string tag, input logic f, input logic [31:0] fpc);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_fault"}, {31'd0, fault}, {31'd0, f});
        check({tag, "_fault_pc"}, fault_pc, fpc);
    endtask

`ifdef INST_FETCH_PERF_EN
    task automatic expect_perf(input string tag, input logic [31:0] f, input logic [31:0] s, input logic [15:0] r);
        check({tag, "_fetch_cnt"}, fetch_count, f);
        check({tag, "_stall_cnt"}, stall_count, s);
        check({tag, "_redir_cnt"}, {16'd0, redirect_count}, {16'd0, r});
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;

        drive(1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        check("rst_rom_addr", rom_addr, 32'h0);
        expect_idle("rst", 1'b0, 32'h0);
        check("rst_state", 32'(state_dbg), 32'(BOOT));

        // BOOT cycle: issue RESET_PC, nothing valid yet
        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("boot_valid", {31'd0, inst_valid}, 32'd0);
        check("boot_rom_addr", rom_addr, 32'h0);
`ifdef INST_FETCH_PERF_EN
        expect_perf("boot", 32'd0, 32'd0, 16'd0);
`endif

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("seq0", 32'h0, 32'h11);
        check("seq0_rom_addr", rom_addr, 32'h4);
        check("seq0_state", 32'(state_dbg), 32'(RUN));

        // Three stall cycles hold the word at 4 and replay its address
        for (int i = 0; i < 3; i++) begin
            next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0);
            expect_word("stall", 32'h4, 32'h22);
            check("stall_rom_addr", rom_addr, 32'h4);
        end

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("release", 32'h4, 32'h22);
        check("release_rom_addr", rom_addr, 32'h8);

        // Redirect beats stall; word at 8 is dropped
        next_cycle(); drive(1'b0, 1'b1, 1'b1, 32'h40);
        expect_word("seq2", 32'h8, 32'h33);
        check("redir_rom_addr", rom_addr, 32'h40);
`ifdef INST_FETCH_PERF_EN
        expect_perf("after_stall", 32'd2, 32'd3, 16'd0);
`endif

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("tgt40", 32'h40, 32'h1000_0010);
        check("tgt40_rom_addr", rom_addr, 32'h44);
`ifdef INST_FETCH_PERF_EN
        expect_perf("after_redir", 32'd2, 32'd4, 16'd1);
`endif

        // Misaligned redirect faults
        next_cycle(); drive(1'b0, 1'b0, 1'b1, 32'h42);
        expect_word("tgt44", 32'h44, 32'h1000_0011);

        // Out-of-range redirect while already faulted updates fault_pc
        next_cycle(); drive(1'b0, 1'b0, 1'b1, 32'h400);
        expect_idle("mis", 1'b1, 32'h42);
        check("mis_rom_addr", rom_addr, 32'h40);

        // Legal redirect leaves FAULT; stall ignored here
        next_cycle(); drive(1'b0, 1'b1, 1'b1, 32'h10);
        expect_idle("oor_in_fault", 1'b1, 32'h400);
        check("resume_rom_addr", rom_addr, 32'h10);

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("resume", 32'h10, 32'h1000_0004);
        check("resume_fault", {31'd0, fault}, 32'd0);
        check("resume_next_addr", rom_addr, 32'h14);

        // Out-of-range redirect from RUN
        next_cycle(); drive(1'b0, 1'b0, 1'b1, 32'h400);
        expect_word("w14", 32'h14, 32'h1000_0005);

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_idle("oor", 1'b1, 32'h400);
        check("oor_state", 32'(state_dbg), 32'(FAULT));

        // Run off the end of the ROM
        next_cycle(); drive(1'b0, 1'b0, 1'b1, 32'h3F8);
        check("end_redir_addr", rom_addr, 32'h3F8);

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("w3f8", 32'h3F8, 32'h1000_00FE);
        check("w3f8_rom_addr", rom_addr, 32'h3FC);

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("w3fc", 32'h3FC, 32'h1000_00FF);

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_idle("end", 1'b1, 32'h400);

        // Reset while faulted
        next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("rstf_rom_addr", rom_addr, 32'h0);

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_idle("rstf", 1'b0, 32'h0);
        check("rstf_pc", pc_out, 32'h0);
        check("rstf_boot_addr", rom_addr, 32'h0);
`ifdef INST_FETCH_PERF_EN
        expect_perf("rstf", 32'd0, 32'd0, 16'd0);
`endif

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("rstf_w0", 32'h0, 32'h11);

        next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0);
        expect_word("rstf_w4", 32'h4, 32'h22);

        // Reset while stalled
        next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("rsts_rom_addr", rom_addr, 32'h0);

        next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0);
        expect_idle("rsts", 1'b0, 32'h0);
        check("rsts_pc", pc_out, 32'h0);
        check("rsts_boot_addr", rom_addr, 32'h0);

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("rsts_w0", 32'h0, 32'h11);

        // Redirect during BOOT
        next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle(); drive(1'b0, 1'b0, 1'b1, 32'h20);
        check("bootredir_rom_addr", rom_addr, 32'h20);

        next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
        expect_word("bootredir", 32'h20, 32'h1000_0008);
        check("bootredir_next", rom_addr, 32'h24);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
